rhd_frame_packer: RTL and testbench



---
 rtl/rhd_pkg.sv | 18 +
 rtl/rhd_frame_buf.sv | 60 ++++++
 rtl/rhd_frame_packer.sv | 159 +++++++++++++++
 tb/tb_rhd_frame_packer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhd_pkg.sv
// rtl/rhd_pkg.sv - shared constants, packet sizing and FSM state type for the frame packer
package rhd_pkg;

    localparam int         N_STREAMS = 32;
    localparam logic [7:0] MAGIC     = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // One header word plus one word per pair of 16-bit streams.
    function automatic int WORDS_PER_PKT(input int n_streams);
        return n_streams / 2 + 1;
    endfunction

endpackage

// File: rtl/rhd_frame_buf.sv
// rtl/rhd_frame_buf.sv - two-slot ping-pong buffer holding captured sample events
module rhd_frame_buf #(
    parameter int N_STREAMS = rhd_pkg::N_STREAMS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_channel,
    input  logic [16*N_STREAMS-1:0]  push_data,
    input  logic                     pop,
    output logic [1:0]               count,
    output logic                     full,
    output logic [7:0]               rd_channel,
    output logic [16*N_STREAMS-1:0]  rd_data,
    output logic [7:0]               nxt_channel
);

    localparam int DW = 16 * N_STREAMS;

    logic [7:0]    chan_q [2];
    logic [DW-1:0] data_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // A push while full or a pop while empty is ignored, so the pointers can never cross.
    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);

    // Capture into the write slot, advance pointers and track occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                chan_q[wr_ptr] <= push_channel;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full        = (count == 2'd2);
    assign rd_channel  = chan_q[rd_ptr];
    assign rd_data     = data_q[rd_ptr];
    // The slot behind the read slot; used to preload the next header back-to-back.
    assign nxt_channel = chan_q[~rd_ptr];

endmodule

// File: rtl/rhd_frame_packer.sv
// rtl/rhd_frame_packer.sv - frames buffered sample events into header + data stream packets
module rhd_frame_packer #(
    parameter int         N_STREAMS = rhd_pkg::N_STREAMS,
    parameter logic [7:0] MAGIC     = rhd_pkg::MAGIC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [7:0]               sample_channel,
    input  logic [16*N_STREAMS-1:0]  sample_data,
    input  logic                     clear,
    output logic [31:0]              m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int WPP = rhd_pkg::WORDS_PER_PKT(N_STREAMS);
    localparam int NDW = WPP - 1;
    localparam int IW  = (NDW > 1) ? $clog2(NDW) : 1;

    rhd_pkg::state_t state, state_nxt;

    logic [IW-1:0]           idx, idx_nxt;
    logic [7:0]              seq, seq_nxt;
    logic [31:0]             tdata_nxt;
    logic                    tvalid_nxt;
    logic                    tlast_nxt;
    logic                    hs;
    logic                    last_hs;
    logic                    push;
    logic                    drop;
    logic [1:0]              count;
    logic                    full;
    logic [7:0]              rd_channel;
    logic [16*N_STREAMS-1:0] rd_data;
    logic [7:0]              nxt_channel;

    assign hs      = m_tvalid && m_tready;
    assign last_hs = hs && (state == rhd_pkg::DATA) && m_tlast;
    // Fullness is judged before this cycle's free, so a slot being released is not reusable yet.
    assign push    = sample_valid && !full;
    assign drop    = sample_valid && full;

    rhd_frame_buf #(
        .N_STREAMS (N_STREAMS)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_channel (sample_channel),
        .push_data    (sample_data),
        .pop          (last_hs),
        .count        (count),
        .full         (full),
        .rd_channel   (rd_channel),
        .rd_data      (rd_data),
        .nxt_channel  (nxt_channel)
    );

    // State, registered stream outputs and packet sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= rhd_pkg::IDLE;
            idx      <= '0;
            seq      <= 8'd0;
            m_tdata  <= 32'd0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            seq      <= seq_nxt;
            m_tdata  <= tdata_nxt;
            m_tvalid <= tvalid_nxt;
            m_tlast  <= tlast_nxt;
        end
    end

    // Next state: start when a slot is full, chain straight into the next packet if one waits.
    always_comb begin
        state_nxt = state;
        case (state)
            rhd_pkg::IDLE: if (count != 2'd0) state_nxt = rhd_pkg::HDR;
            rhd_pkg::HDR:  if (hs) state_nxt = rhd_pkg::DATA;
            rhd_pkg::DATA: if (last_hs) state_nxt = (count == 2'd2) ? rhd_pkg::HDR : rhd_pkg::IDLE;
            default:       state_nxt = rhd_pkg::IDLE;
        endcase
    end

    // Output word mux: outputs only change when idle-loading or on a handshake, keeping them stable under stall.
    always_comb begin
        idx_nxt    = idx;
        seq_nxt    = seq;
        tdata_nxt  = m_tdata;
        tvalid_nxt = m_tvalid;
        tlast_nxt  = m_tlast;
        case (state)
            rhd_pkg::IDLE: begin
                if (count != 2'd0) begin
                    tdata_nxt  = {MAGIC, seq, drop_cnt, rd_channel};
                    tvalid_nxt = 1'b1;
                    tlast_nxt  = 1'b0;
                end
            end
            rhd_pkg::HDR: begin
                if (hs) begin
                    idx_nxt   = '0;
                    tdata_nxt = rd_data[31:0];
                    tlast_nxt = (NDW == 1);
                end
            end
            rhd_pkg::DATA: begin
                if (hs) begin
                    if (m_tlast) begin
                        seq_nxt = seq + 8'd1;
                        if (count == 2'd2) begin
                            tdata_nxt = {MAGIC, seq + 8'd1, drop_cnt, nxt_channel};
                            tlast_nxt = 1'b0;
                        end else begin
                            tdata_nxt  = 32'd0;
                            tvalid_nxt = 1'b0;
                            tlast_nxt  = 1'b0;
                        end
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        tdata_nxt = rd_data[{idx_nxt, 5'd0} +: 32];
                        tlast_nxt = (idx_nxt == IW'(NDW - 1));
                    end
                end
            end
            default: begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
            end
        endcase
    end

    // Overrun bookkeeping: a drop in the same cycle as clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_rhd_frame_packer.sv
// tb/tb_rhd_frame_packer.sv - self-checking bench for rhd_frame_packer
module tb_rhd_frame_packer;

    localparam int NS = 32;
    localparam int NW = NS / 2 + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_valid = 1'b0;
    logic [7:0]        sample_channel = 8'd0;
    logic [16*NS-1:0]  sample_data = '0;
    logic              clear = 1'b0;
    logic              m_tready = 1'b0;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] cap_d [$];
    logic        cap_l [$];

    logic        stall = 1'b0;
    logic [31:0] hold_d = 32'd0;
    logic        hold_l = 1'b0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
    } wvec_t;

    typedef struct {
        logic [7:0]  ch;
        logic [15:0] base;
        logic [7:0]  seq;
        logic [7:0]  drop;
    } ev_t;

    wvec_t       wt [5];
    ev_t         ev [3];
    logic [15:0] b4 [4];

    always #5 clk = ~clk;

    rhd_frame_packer #(
        .N_STREAMS (NS),
        .MAGIC     (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .sample_channel (sample_channel),
        .sample_data    (sample_data),
        .clear          (clear),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Capture accepted words away from the clock edge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            cap_d.push_back(m_tdata);
            cap_l.push_back(m_tlast);
        end
    end

    // A stalled word must stay put until accepted.
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
                chk("stall_data", m_tdata, hold_d);
                chk("stall_last", {31'd0, m_tlast}, {31'd0, hold_l});
            end
            stall  = m_tvalid && !m_tready;
            hold_d = m_tdata;
            hold_l = m_tlast;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sample_valid = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap_d.delete();
        cap_l.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic [15:0] base);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_channel = ch;
        for (int k = 0; k < NS; k++) sample_data[16*k +: 16] = base + 16'(k);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_words(input string nm, input int n, input int budget);
        int c;
        c = 0;
        while (cap_d.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (cap_d.size() < n) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d words required=%0d", nm, cap_d.size(), n);
        end
    endtask

    task automatic expect_pkt(input string nm, input logic [7:0] ch, input logic [7:0] seq,
                              input logic [7:0] drop, input logic [15:0] base);
        logic [31:0] ew;
        logic        el;
        for (int i = 0; i < NW; i++) begin
            if (cap_d.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_missing actual=none required=word%0d", nm, i);
                return;
            end
            ew = (i == 0) ? {8'hA5, seq, drop, ch}
                          : {base + 16'(2*i - 1), base + 16'(2*i - 2)};
            el = (i == NW - 1);
            chk($sformatf("%s_w%0d", nm, i), cap_d.pop_front(), ew);
            chk($sformatf("%s_l%0d", nm, i), {31'd0, cap_l.pop_front()}, {31'd0, el});
        end
    endtask

    initial begin
        wt[0] = '{0,  32'hA500_0005, 1'b0};
        wt[1] = '{1,  32'h1001_1000, 1'b0};
        wt[2] = '{2,  32'h1003_1002, 1'b0};
        wt[3] = '{15, 32'h101D_101C, 1'b0};
        wt[4] = '{16, 32'h101F_101E, 1'b1};

        ev[0] = '{8'h11, 16'h2000, 8'd0, 8'd0};
        ev[1] = '{8'h22, 16'h3000, 8'd1, 8'd0};
        ev[2] = '{8'h33, 16'h4000, 8'd2, 8'd0};

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // 1: single event, latency and word table
        m_tready = 1'b1;
        send(8'h05, 16'h1000);
        @(negedge clk);
        chk("t1_lat_t1_valid", {31'd0, m_tvalid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_t2_valid", {31'd0, m_tvalid}, 32'd1);
        chk("t1_lat_t2_data", m_tdata, 32'hA500_0005);
        wait_words("t1", NW, 60);
        if (cap_d.size() >= NW) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t1_tab_w%0d", wt[i].idx), cap_d[wt[i].idx], wt[i].data);
                chk($sformatf("t1_tab_l%0d", wt[i].idx), {31'd0, cap_l[wt[i].idx]}, {31'd0, wt[i].last});
            end
        end
        expect_pkt("t1", 8'h05, 8'd0, 8'd0, 16'h1000);

        // 2: three spaced events
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(ev[i].ch, ev[i].base);
            idle(20);
        end
        wait_words("t2", 3 * NW, 100);
        for (int i = 0; i < 3; i++)
            expect_pkt($sformatf("t2p%0d", i), ev[i].ch, ev[i].seq, ev[i].drop, ev[i].base);
        chk("t2_overflow", {31'd0, overflow}, 32'd0);
        chk("t2_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // 3: backpressure with three strobes
        do_reset();
        m_tready = 1'b0;
        send(8'h31, 16'h5000);
        idle(3);
        send(8'h32, 16'h6000);
        idle(3);
        send(8'h33, 16'h7000);
        @(negedge clk);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_words("t3", 2 * NW, 100);
        expect_pkt("t3p0", 8'h31, 8'd0, 8'd0, 16'h5000);
        expect_pkt("t3p1", 8'h32, 8'd1, 8'd1, 16'h6000);
        idle(10);
        @(negedge clk);
        chk("t3_extra_words", cap_d.size(), 32'd0);
        chk("t3_idle_valid", {31'd0, m_tvalid}, 32'd0);

        // 4: random backpressure
        do_reset();
        for (int e = 0; e < 4; e++) b4[e] = 16'($urandom);
        fork
            begin
                for (int e = 0; e < 4; e++) begin
                    send(8'h40 + 8'(e), b4[e]);
                    idle(60);
                end
            end
            begin
                repeat (300) begin
                    @(posedge clk); #1;
                    m_tready = 1'($urandom_range(0, 1));
                end
                m_tready = 1'b1;
            end
        join
        wait_words("t4", 4 * NW, 300);
        for (int e = 0; e < 4; e++)
            expect_pkt($sformatf("t4p%0d", e), 8'h40 + 8'(e), 8'(e), 8'd0, b4[e]);
        chk("t4_overflow", {31'd0, overflow}, 32'd0);

        // 5: saturation, clear-vs-drop, clear alone
        do_reset();
        m_tready = 1'b0;
        send(8'h51, 16'h9000);
        send(8'h52, 16'hA000);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("t5_sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
        chk("t5_sat_overflow", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        sample_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        chk("t5_clrdrop_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        chk("t5_clrdrop_overflow", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("t5_clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("t5_clr_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_words("t5", 2 * NW, 100);
        expect_pkt("t5p0", 8'h51, 8'd0, 8'd0, 16'h9000);
        expect_pkt("t5p1", 8'h52, 8'd1, 8'd0, 16'hA000);

        // 6: reset mid-packet
        do_reset();
        m_tready = 1'b1;
        send(8'h5A, 16'hB000);
        wait_words("t6_pre", 9, 40);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("t6_rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("t6_rst_tdata", m_tdata, 32'd0);
        chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("t6_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        cap_d.delete();
        cap_l.delete();
        idle(10);
        @(negedge clk);
        chk("t6_no_resume_valid", {31'd0, m_tvalid}, 32'd0);
        chk("t6_no_resume_words", cap_d.size(), 32'd0);
        send(8'h66, 16'h8000);
        wait_words("t6", NW, 60);
        expect_pkt("t6p0", 8'h66, 8'd0, 8'd0, 16'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
